// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit confidence replacement.
// F-stage lookup is combinational; the D-stage output register adds one cycle.
module branch_target_buffer #(
  parameter int unsigned BTB_DEPTH = 6,
  parameter int unsigned TAG_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcF,
  input  logic [31:0] pcM,
  input  logic        branchM,
  input  logic        actual_takeM,
  input  logic [31:0] actual_targetM,
  output logic        btb_hitD,
  output logic [31:0] btb_targetD
);

  localparam int unsigned Entries = 1 << BTB_DEPTH;

  typedef logic [BTB_DEPTH-1:0] idx_t;
  typedef logic [TAG_W-1:0]     tag_t;

  logic [Entries-1:0]       valid_q;
  logic [Entries-1:0][1:0]  conf_q;
  tag_t                     tag_q    [Entries];
  logic [29:0]              target_q [Entries];

  idx_t idx_f, idx_m;
  tag_t tag_f, tag_m;

  assign idx_f = pcF[BTB_DEPTH+1:2];
  assign tag_f = pcF[BTB_DEPTH+TAG_W+1:BTB_DEPTH+2];
  assign idx_m = pcM[BTB_DEPTH+1:2];
  assign tag_m = pcM[BTB_DEPTH+TAG_W+1:BTB_DEPTH+2];

  // Address bits outside idx/tag and the target's byte offset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{pcF, pcM, actual_targetM[1:0]};

  // F-stage lookup reads the pre-update contents (no write bypass).
  logic        hit_f;
  logic [31:0] target_f;

  assign hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign target_f = {target_q[idx_f], 2'b00};

  // Update decode for the single entry selected by pcM.
  logic       upd_hit;
  logic [1:0] cur_conf;
  logic       set_valid;
  logic       clr_valid;
  logic       conf_we;
  logic [1:0] conf_nxt;
  logic       tag_we;
  logic       target_we;

  assign cur_conf = conf_q[idx_m];
  assign upd_hit  = valid_q[idx_m] && (tag_q[idx_m] == tag_m);

  always_comb begin
    set_valid = 1'b0;
    clr_valid = 1'b0;
    conf_we   = 1'b0;
    conf_nxt  = cur_conf;
    tag_we    = 1'b0;
    target_we = 1'b0;
    if (branchM) begin
      if (upd_hit) begin
        if (actual_takeM) begin
          target_we = 1'b1;
          conf_we   = 1'b1;
          conf_nxt  = (cur_conf == 2'd3) ? 2'd3 : cur_conf + 2'd1;
        end else if (cur_conf != 2'd0) begin
          conf_we  = 1'b1;
          conf_nxt = cur_conf - 2'd1;
        end else begin
          clr_valid = 1'b1;
        end
      end else if (actual_takeM) begin
        if (!valid_q[idx_m] || (cur_conf == 2'd0)) begin
          set_valid = 1'b1;
          tag_we    = 1'b1;
          target_we = 1'b1;
          conf_we   = 1'b1;
          conf_nxt  = 2'd1;
        end else begin
          // Resident entry defends its slot; it loses one confidence step.
          conf_we  = 1'b1;
          conf_nxt = cur_conf - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      conf_q  <= '0;
    end else begin
      if (set_valid) begin
        valid_q[idx_m] <= 1'b1;
      end else if (clr_valid) begin
        valid_q[idx_m] <= 1'b0;
      end
      if (conf_we) begin
        conf_q[idx_m] <= conf_nxt;
      end
    end
  end

  // Tag/target need no reset: valid masks them. Writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (rst && tag_we) begin
      tag_q[idx_m] <= tag_m;
    end
    if (rst && target_we) begin
      target_q[idx_m] <= actual_targetM[31:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_hitD    <= 1'b0;
      btb_targetD <= '0;
    end else if (flushD) begin
      btb_hitD    <= 1'b0;
      btb_targetD <= '0;
    end else if (!stallD) begin
      btb_hitD    <= hit_f;
      btb_targetD <= target_f;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed scenarios followed by
// randomized traffic, checked against a table-level reference model.
module tb_branch_target_buffer;

  localparam int D = 6;
  localparam int T = 8;
  localparam int N = 1 << D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic [31:0] pcF = '0;
  logic [31:0] pcM = '0;
  logic        branchM = 1'b0;
  logic        actual_takeM = 1'b0;
  logic [31:0] actual_targetM = '0;
  logic        btb_hitD;
  logic [31:0] btb_targetD;

  always #5 clk = ~clk;

  branch_target_buffer #(
    .BTB_DEPTH(D),
    .TAG_W    (T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallD        (stallD),
    .flushD        (flushD),
    .pcF           (pcF),
    .pcM           (pcM),
    .branchM       (branchM),
    .actual_takeM  (actual_takeM),
    .actual_targetM(actual_targetM),
    .btb_hitD      (btb_hitD),
    .btb_targetD   (btb_targetD)
  );

  // Reference table
  bit          m_valid   [N];
  int          m_conf    [N];
  bit [T-1:0]  m_tag     [N];
  bit [31:0]   m_target  [N];
  bit          m_written [N];

  // Reference D register; known=0 means the target comes from a never-written slot.
  bit        d_hit;
  bit [31:0] d_tgt;
  bit        d_known;

  typedef struct {
    bit        hit;
    bit [31:0] tgt;
    bit        known;
    int        seq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   seq_no = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[D+1:2]);
  endfunction

  function automatic bit [T-1:0] tag_of(input logic [31:0] pc);
    return pc[D+T+1:D+2];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_conf[i]  = 0;
    end
    d_hit   = 1'b0;
    d_tgt   = '0;
    d_known = 1'b1;
  endtask

  task automatic model_update(input logic [31:0] pm, input bit tk, input logic [31:0] tg);
    int i;
    bit hit;
    i   = idx_of(pm);
    hit = m_valid[i] && (m_tag[i] == tag_of(pm));
    if (hit && tk) begin
      m_target[i]  = {tg[31:2], 2'b00};
      m_written[i] = 1'b1;
      if (m_conf[i] < 3) m_conf[i] = m_conf[i] + 1;
    end else if (hit) begin
      if (m_conf[i] > 0) m_conf[i] = m_conf[i] - 1;
      else m_valid[i] = 1'b0;
    end else if (tk) begin
      if (!m_valid[i] || m_conf[i] == 0) begin
        m_valid[i]   = 1'b1;
        m_tag[i]     = tag_of(pm);
        m_target[i]  = {tg[31:2], 2'b00};
        m_written[i] = 1'b1;
        m_conf[i]    = 1;
      end else begin
        m_conf[i] = m_conf[i] - 1;
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the D-stage value expected after the next posedge.
  task automatic cycle(input bit st, input bit fl, input logic [31:0] pf, input bit br,
                       input logic [31:0] pm, input bit tk, input logic [31:0] tg);
    int   i;
    exp_t e;
    @(negedge clk);
    stallD         = st;
    flushD         = fl;
    pcF            = pf;
    branchM        = br;
    pcM            = pm;
    actual_takeM   = tk;
    actual_targetM = tg;
    if (fl) begin
      d_hit   = 1'b0;
      d_tgt   = '0;
      d_known = 1'b1;
    end else if (!st) begin
      i       = idx_of(pf);
      d_hit   = m_valid[i] && (m_tag[i] == tag_of(pf));
      d_tgt   = m_target[i];
      d_known = m_written[i];
    end
    e.hit   = d_hit;
    e.tgt   = d_tgt;
    e.known = d_known;
    e.seq   = seq_no;
    seq_no++;
    q.push_back(e);
    if (br) model_update(pm, tk, tg);
  endtask

  task automatic look(input logic [31:0] pf);
    cycle(1'b0, 1'b0, pf, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pf, input logic [31:0] pm, input bit tk,
                     input logic [31:0] tg);
    cycle(1'b0, 1'b0, pf, 1'b1, pm, tk, tg);
  endtask

  // Monitor: the D register is sampled 1 time unit after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (btb_hitD !== e.hit || (e.known && btb_targetD !== e.tgt)) begin
        failures++;
        $display("FAIL d_out seq=%0d got hit=%0b tgt=%h expected hit=%0b tgt=%h (tgt checked=%0b)",
                 e.seq, btb_hitD, btb_targetD, e.hit, e.tgt, e.known);
      end
    end
  end

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] pf;
    logic [31:0] pm;
    logic [31:0] tg;
    logic [7:0]  tsel;
    logic [5:0]  isel;

    for (int i = 0; i < N; i++) begin
      m_written[i] = 1'b0;
      m_tag[i]     = '0;
      m_target[i]  = '0;
    end
    model_reset();

    #12;
    check_now("reset_hit", {31'b0, btb_hitD}, 32'h0);
    check_now("reset_target", btb_targetD, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Cold miss then allocate
    look(32'h0040_0010);
    upd(32'h0, 32'h0040_0010, 1'b1, 32'h0040_0100);
    look(32'h0040_0010);

    // Conflict without replacement, then replacement once confidence is spent
    upd(32'h0040_0010, 32'h0040_0010, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0040_0110, 1'b1, 32'h0040_0200);
    upd(32'h0040_0010, 32'h0040_0110, 1'b1, 32'h0040_0200);
    upd(32'h0040_0010, 32'h0040_0110, 1'b1, 32'h0040_0200);
    look(32'h0040_0110);
    look(32'h0040_0010);

    // Decay to invalid
    upd(32'h0, 32'h0040_0020, 1'b1, 32'h0040_0300);
    upd(32'h0040_0020, 32'h0040_0020, 1'b0, 32'h0);
    upd(32'h0040_0020, 32'h0040_0020, 1'b0, 32'h0);
    look(32'h0040_0020);

    // Stall holds, flush wins over stall
    look(32'h0040_0110);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0040_0110, 1'b0, 32'h0, 1'b0, 32'h0);
    look(32'h0040_0110);

    // Same-cycle lookup and update: lookup sees the old target
    upd(32'h0040_0110, 32'h0040_0110, 1'b1, 32'h0040_0503);
    look(32'h0040_0110);

    // Asynchronous reset mid-cycle with an update in flight
    @(posedge clk);
    #3;
    check_now("pre_reset_hit", {31'b0, btb_hitD}, {31'b0, d_hit});
    rst            = 1'b0;
    branchM        = 1'b1;
    pcM            = 32'h0040_0030;
    actual_takeM   = 1'b1;
    actual_targetM = 32'h0040_0700;
    #1;
    check_now("async_reset_hit", {31'b0, btb_hitD}, 32'h0);
    check_now("async_reset_target", btb_targetD, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    branchM = 1'b0;
    model_reset();
    look(32'h0040_0110);
    look(32'h0040_0030);

    // Randomized traffic over a few colliding indices and tags
    for (int k = 0; k < 600; k++) begin
      r    = $urandom;
      tsel = 8'($urandom_range(0, 2));
      isel = 6'($urandom_range(4, 6));
      pf   = {r[31:16], tsel, isel, r[1:0]};
      r    = $urandom;
      tsel = 8'($urandom_range(0, 2));
      isel = 6'($urandom_range(4, 6));
      pm   = {r[31:16], tsel, isel, r[1:0]};
      tg   = $urandom;
      cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), pf,
            ($urandom_range(0, 1) == 1), pm, ($urandom_range(0, 2) != 0), tg);
    end

    for (int k = 0; k < 3; k++) look(32'h0040_0010);
    @(posedge clk);
    #3;
    check_now("queue_drained", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter BTB_DEPTH, default 6, log2 of entry count (64 entries).
REQ-002 SHALL have parameter TAG_W, default 8, tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port stallD  input  1  hold the D-stage output register.
REQ-006 SHALL have port flushD  input  1  clear the D-stage output register.
REQ-007 SHALL have port pcF  input  32  fetch PC to look up.
REQ-008 SHALL have port pcM  input  32  PC of the resolving instruction in M.
REQ-009 SHALL have port branchM  input  1  M instruction is a branch; update enable.
REQ-010 SHALL have port actual_takeM  input  1  resolved direction in M.
REQ-011 SHALL have port actual_targetM  input  32  resolved target in M; bits [1:0] are ignored.
REQ-012 SHALL have port btb_hitD  output  1  D-stage flag: a valid entry matched pcF of the instruction now in D.
REQ-013 SHALL have port btb_targetD  output  32  D-stage predicted target, with bits [1:0]=00.

Function
REQ-014 SHALL index with idx(pc)=pc[BTB_DEPTH+1:2] and tag(pc)=pc[BTB_DEPTH+TAG_W+1:BTB_DEPTH+2].
REQ-015 SHALL store per entry: valid (1), tag (TAG_W), target[31:2] (30), and a 2-bit confidence counter conf.
REQ-016 SHALL produce the F-stage lookup combinationally: hitF = valid[idx] & (tag==tag(pcF)); targetF = {target[idx],2'b00}.
REQ-017 SHALL register hitF/targetF into btb_hitD/btb_targetD every cycle, giving one-cycle latency from pcF.
REQ-018 SHALL give the D register the priority flushD > stallD > load; flushD sets hit=0 and target=0; stallD holds both.
REQ-019 SHALL perform updates only when branchM=1, writing at most one entry (idx(pcM)) per cycle.
REQ-020 SHALL, on an update hit with taken: write the target and increment conf, saturating at 3.
REQ-021 SHALL, on an update hit with not-taken: when conf>0, decrement conf; when conf==0, clear valid.
REQ-022 SHALL, on an update miss with taken: when the entry is invalid or conf==0, allocate it (valid=1, tag, target, conf=1); otherwise decrement conf and leave the entry in place.
REQ-023 SHALL leave the table unchanged on an update miss with not-taken.
REQ-024 SHALL give a lookup and an update to the same index in the same cycle the pre-update contents (read-before-write, no bypass).
REQ-025 SHALL assert btb_hitD only as the registered hitF; it SHALL NOT depend on branchM or stall state combinationally.
REQ-026 SHALL ignore actual_takeM and actual_targetM when branchM=0.

Reset
REQ-027 SHALL, while rst=0 and independent of clk, clear all valid bits, all conf to 0, btb_hitD=0, and btb_targetD=0.
REQ-028 SHALL let an update in flight when reset asserts take no effect; the first post-reset lookup of any PC SHALL miss.
REQ-029 SHALL not require tag/target contents to be cleared, since valid=0 masks them.

Verification
REQ-030 Cold miss then allocate: after reset, pcF=0x00400010 -> btb_hitD=0 next cycle; then branchM=1, pcM=0x00400010, take=1, target=0x00400100; later pcF=0x00400010 -> btb_hitD=1, btb_targetD=0x00400100.
REQ-031 Conflict without replacement: entry at 0x00400010 with conf=2; taken miss for pcM=0x00400110 (same idx, different tag) -> entry unchanged, conf=1; second such miss -> conf=0; third -> replaced, lookup 0x00400110 hits.
REQ-032 Decay to invalid: allocate (conf=1); two not-taken updates -> conf 0 then invalid; lookup -> btb_hitD=0.
REQ-033 Pipeline control: a hit on pcF with stallD=1 for 3 cycles holds btb_hitD/btb_targetD; a simultaneous stallD=1 and flushD=1 -> btb_hitD=0, btb_targetD=0.
REQ-034 Same-cycle collision: lookup and taken update of a new target at the same idx/tag in one cycle -> btb_targetD shows the old target; the next lookup shows the new one.
REQ-035 Async reset: drop rst mid-cycle while btb_hitD=1 -> btb_hitD=0 immediately, without waiting for clk; after release, a previously allocated PC misses.
